// File: rtl/lsu_dmem_master_if.sv
// Core request/response channel and word-wide data-memory port of the load/store unit.
// The master modport is the unit; the slave modport is the core plus the data memory.
interface lsu_dmem_master_if;
   logic        req_vld;
   logic        req_rdy;
   logic        req_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_dat;

   logic        resp_vld;
   logic [31:0] load_dat;
   logic        exc_misaligned;
   logic        exc_access;
   logic        exc_illegal;

   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_wr_dat;
   logic [31:0] mem_rd_dat;

   modport master (
      input  req_vld, req_write, funct3, addr, store_dat, mem_rd_dat,
      output req_rdy, resp_vld, load_dat, exc_misaligned, exc_access, exc_illegal,
             mem_read, mem_write, mem_addr, mem_funct3, mem_wr_dat
   );

   modport slave (
      output req_vld, req_write, funct3, addr, store_dat, mem_rd_dat,
      input  req_rdy, resp_vld, load_dat, exc_misaligned, exc_access, exc_illegal,
             mem_read, mem_write, mem_addr, mem_funct3, mem_wr_dat
   );
endinterface

// File: rtl/lsu_dmem_master.sv
// Load/store unit: one request at a time, word-only memory accesses, read-modify-write for SB/SH.
// Latency from accept: load/SW 2, SB/SH 3, fault 1; ready only in IDLE, response pulse has no backpressure.
module lsu_dmem_master #(
   parameter int MEM_SIZE_KB = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   lsu_dmem_master_if.master bus
);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_SIZE_KB) * 32'd1024;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_RD,
      WRITE,
      RESP
   } state_t;

   state_t      state;
   state_t      state_d;

   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] store_q;
   logic [31:0] rdat_q;
   logic [31:0] load_q;
   logic        exc_illegal_q;
   logic        exc_misaligned_q;
   logic        exc_access_q;

   logic        accept;
   logic        f3_illegal;
   logic        misaligned;
   logic        out_of_range;
   logic        fault;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign accept = (state == IDLE) && bus.req_vld && !i_rst;

   // Fault checks are one-hot: an illegal code masks alignment, alignment masks range.
   always_comb begin
      f3_illegal = 1'b1;
      case (bus.funct3)
         3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
         3'b100, 3'b101:         f3_illegal = bus.req_write;
         default:                f3_illegal = 1'b1;
      endcase
      misaligned = !f3_illegal &&
                   (((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                    ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00)));
      out_of_range = !f3_illegal && !misaligned && (bus.addr >= MEM_BYTES);
      fault = f3_illegal || misaligned || out_of_range;
   end

   always_comb begin
      byte_lane = 8'h00;
      case (addr_q[1:0])
         2'b00:   byte_lane = bus.mem_rd_dat[7:0];
         2'b01:   byte_lane = bus.mem_rd_dat[15:8];
         2'b10:   byte_lane = bus.mem_rd_dat[23:16];
         default: byte_lane = bus.mem_rd_dat[31:24];
      endcase
      half_lane = addr_q[1] ? bus.mem_rd_dat[31:16] : bus.mem_rd_dat[15:0];
      load_ext = bus.mem_rd_dat;
      case (funct3_q)
         3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
         3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
         3'b100:  load_ext = {24'h000000, byte_lane};
         3'b101:  load_ext = {16'h0000, half_lane};
         default: load_ext = bus.mem_rd_dat;
      endcase
   end

   always_comb begin
      merged = rdat_q;
      case (funct3_q[1:0])
         2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = store_q[7:0];
         2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = store_q[15:0];
         default: merged = store_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d            = state;
      bus.req_rdy        = 1'b0;
      bus.resp_vld       = 1'b0;
      bus.load_dat       = 32'h0;
      bus.exc_illegal    = 1'b0;
      bus.exc_misaligned = 1'b0;
      bus.exc_access     = 1'b0;
      bus.mem_read       = 1'b0;
      bus.mem_write      = 1'b0;
      bus.mem_addr       = 32'h0;
      bus.mem_wr_dat     = 32'h0;
      bus.mem_funct3     = 3'b010;

      case (state)
         IDLE: begin
            if (accept) begin
               if (fault) begin
                  state_d = RESP;
               end else if (!bus.req_write) begin
                  state_d = LOAD;
               end else if (bus.funct3[1:0] == 2'b10) begin
                  state_d = WRITE;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         LOAD:    state_d = RESP;
         RMW_RD:  state_d = WRITE;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Reset overrides every output so a store caught mid-flight never reaches memory.
      if (!i_rst) begin
         bus.mem_addr = {addr_q[31:2], 2'b00};
         case (state)
            IDLE:         bus.req_rdy = 1'b1;
            LOAD, RMW_RD: bus.mem_read = 1'b1;
            WRITE: begin
               bus.mem_write  = 1'b1;
               bus.mem_wr_dat = merged;
            end
            RESP: begin
               bus.resp_vld       = 1'b1;
               bus.load_dat       = load_q;
               bus.exc_illegal    = exc_illegal_q;
               bus.exc_misaligned = exc_misaligned_q;
               bus.exc_access     = exc_access_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         funct3_q         <= 3'b000;
         addr_q           <= 32'h0;
         store_q          <= 32'h0;
         rdat_q           <= 32'h0;
         load_q           <= 32'h0;
         exc_illegal_q    <= 1'b0;
         exc_misaligned_q <= 1'b0;
         exc_access_q     <= 1'b0;
      end else begin
         if (accept) begin
            funct3_q         <= bus.funct3;
            addr_q           <= bus.addr;
            store_q          <= bus.store_dat;
            load_q           <= 32'h0;
            exc_illegal_q    <= f3_illegal;
            exc_misaligned_q <= misaligned;
            exc_access_q     <= out_of_range;
         end
         if (state == LOAD) begin
            load_q <= load_ext;
         end
         if (state == RMW_RD) begin
            rdat_q <= bus.mem_rd_dat;
         end
      end
   end
endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: directed vector table, reset and back-to-back sequences,
// then random requests against a byte-array reference of the memory.
module tb_lsu_dmem_master;
   logic i_clk = 1'b0;
   logic i_rst;
   logic preload;

   lsu_dmem_master_if bus ();

   lsu_dmem_master #(.MEM_SIZE_KB(1)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   logic [31:0] dmem     [0:255];
   logic [31:0] init_val [0:255];
   logic [7:0]  ref_b    [0:1023];
   bit   [2:0]  legal_ld [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   int          n_checks = 0;
   int          n_pass   = 0;

   assign bus.mem_rd_dat = dmem[bus.mem_addr[9:2]];

   always @(posedge i_clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) dmem[i] <= init_val[i];
      end else if (bus.mem_write) begin
         dmem[bus.mem_addr[9:2]] <= bus.mem_wr_dat;
      end
   end

   typedef struct {
      bit        wr;
      bit [2:0]  f3;
      bit [31:0] a;
      bit [31:0] sd;
      bit [31:0] ld;
      bit [2:0]  exc;
      int        lat;
      int        widx;
      bit [31:0] wval;
   } vec_t;

   typedef struct {
      bit        wr;
      bit [2:0]  f3;
      bit [31:0] a;
      bit [31:0] sd;
   } req_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   function automatic logic [31:0] ref_word(input int w);
      return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
   endfunction

   // Reference: legality, alignment and range from the ISA rules; data via the byte array.
   function automatic void model(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                                 input bit [31:0] sd, output bit [31:0] ld,
                                 output bit [2:0] exc, output int lat);
      int size;
      bit legal;
      legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = 1 << f3[1:0];
      exc   = 3'b000;
      ld    = 32'h0;
      if (!legal)                  exc = 3'b100;
      else if (a % size != 0)      exc = 3'b010;
      else if (a >= 32'd1024)      exc = 3'b001;
      if (exc != 3'b000) begin
         lat = 1;
         return;
      end
      if (!wr) begin
         for (int i = size - 1; i >= 0; i--) ld = (ld << 8) | 32'(ref_b[a + i]);
         if (!f3[2] && size < 4 && ld[size*8-1]) ld = ld | ~((32'd1 << (size * 8)) - 32'd1);
         lat = 2;
      end else begin
         for (int i = 0; i < size; i++) ref_b[a + i] = sd[8*i +: 8];
         lat = (size == 4) ? 2 : 3;
      end
   endfunction

   task automatic drive_req(input bit wr, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] sd);
      bus.req_write = wr;
      bus.funct3    = f3;
      bus.addr      = a;
      bus.store_dat = sd;
   endtask

   task automatic run_req(input bit wr, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] sd,
                          output int rc, output int rdc, output int wrc, output int nrd,
                          output int nwr, output bit [31:0] ld, output bit [2:0] ex,
                          output bit bus_ok);
      int w;
      rc = -1; rdc = -1; wrc = -1; nrd = 0; nwr = 0; ld = 32'h0; ex = 3'b000; bus_ok = 1'b1;
      @(negedge i_clk);
      w = 0;
      while (!bus.req_rdy && w < 10) begin
         @(negedge i_clk);
         w++;
      end
      drive_req(wr, f3, a, sd);
      bus.req_vld = 1'b1;
      @(posedge i_clk);
      #1 bus.req_vld = 1'b0;
      for (int k = 1; k <= 8 && rc < 0; k++) begin
         @(negedge i_clk);
         if (bus.mem_read) begin
            nrd++;
            if (rdc < 0) rdc = k;
         end
         if (bus.mem_write) begin
            nwr++;
            if (wrc < 0) wrc = k;
         end
         if ((bus.mem_read || bus.mem_write) &&
             (bus.mem_addr != {a[31:2], 2'b00} || bus.mem_funct3 != 3'b010)) bus_ok = 1'b0;
         if (bus.resp_vld) begin
            rc = k;
            ld = bus.load_dat;
            ex = {bus.exc_illegal, bus.exc_misaligned, bus.exc_access};
         end
      end
   endtask

   task automatic exec_check(input string tag, input bit wr, input bit [2:0] f3, input bit [31:0] a,
                             input bit [31:0] sd, input bit [31:0] e_ld, input bit [2:0] e_exc,
                             input int e_lat);
      int rc, rdc, wrc, nrd, nwr, e_rd, e_wr;
      bit [31:0] ld;
      bit [2:0] ex;
      bit bus_ok;
      run_req(wr, f3, a, sd, rc, rdc, wrc, nrd, nwr, ld, ex, bus_ok);
      e_rd = (e_exc != 3'b000 || (wr && f3 == 3'b010)) ? -1 : 1;
      e_wr = (e_exc != 3'b000 || !wr) ? -1 : e_lat - 1;
      check({tag, " resp_cycle"}, rc, e_lat);
      check({tag, " load_dat"}, ld, e_ld);
      check({tag, " exc"}, 32'(ex), 32'(e_exc));
      check({tag, " read_cycle"}, rdc, e_rd);
      check({tag, " write_cycle"}, wrc, e_wr);
      check({tag, " read_count"}, nrd, (e_rd < 0) ? 0 : 1);
      check({tag, " write_count"}, nwr, (e_wr < 0) ? 0 : 1);
      check({tag, " mem_addr"}, 32'(bus_ok), 32'd1);
   endtask

   vec_t      vt [16];
   req_t      bb [4];
   bit [31:0] bb_ld [4];

   initial begin
      bit [31:0] d_ld;
      bit [2:0]  d_ex;
      int        d_lat;

      bus.req_vld = 1'b0;
      drive_req(1'b0, 3'b000, 32'h0, 32'h0);
      i_rst   = 1'b1;
      preload = 1'b1;
      for (int i = 0; i < 256; i++) init_val[i] = $urandom;
      init_val[4]   = 32'h8765_43F1;
      init_val[8]   = 32'hAABB_CCDD;
      init_val[255] = 32'h1234_5678;
      for (int i = 0; i < 1024; i++) ref_b[i] = init_val[i/4][8*(i%4) +: 8];

      @(posedge i_clk);
      #1 preload = 1'b0;
      @(negedge i_clk);
      check("reset req_rdy", 32'(bus.req_rdy), 32'd0);
      check("reset resp_vld", 32'(bus.resp_vld), 32'd0);
      check("reset mem_rw", {30'h0, bus.mem_read, bus.mem_write}, 32'd0);
      check("reset mem_addr", bus.mem_addr, 32'h0);
      check("reset mem_funct3", 32'(bus.mem_funct3), 32'd2);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check("post-reset req_rdy", 32'(bus.req_rdy), 32'd1);

      vt[0]  = '{1'b0, 3'b000, 32'h11,  32'h0,    32'h0000_0043, 3'b000, 2, -1, 32'h0};
      vt[1]  = '{1'b0, 3'b000, 32'h10,  32'h0,    32'hFFFF_FFF1, 3'b000, 2, -1, 32'h0};
      vt[2]  = '{1'b0, 3'b100, 32'h10,  32'h0,    32'h0000_00F1, 3'b000, 2, -1, 32'h0};
      vt[3]  = '{1'b0, 3'b001, 32'h12,  32'h0,    32'hFFFF_8765, 3'b000, 2, -1, 32'h0};
      vt[4]  = '{1'b0, 3'b101, 32'h12,  32'h0,    32'h0000_8765, 3'b000, 2, -1, 32'h0};
      vt[5]  = '{1'b1, 3'b000, 32'h22,  32'h11,   32'h0,         3'b000, 3, 8,  32'hAA11_CCDD};
      vt[6]  = '{1'b1, 3'b001, 32'h20,  32'h5566, 32'h0,         3'b000, 3, 8,  32'hAA11_5566};
      vt[7]  = '{1'b0, 3'b010, 32'h20,  32'h0,    32'hAA11_5566, 3'b000, 2, -1, 32'h0};
      vt[8]  = '{1'b0, 3'b010, 32'h102, 32'h0,    32'h0,         3'b010, 1, -1, 32'h0};
      vt[9]  = '{1'b1, 3'b001, 32'h1,   32'hFFFF, 32'h0,         3'b010, 1, -1, 32'h0};
      vt[10] = '{1'b0, 3'b001, 32'h3,   32'h0,    32'h0,         3'b010, 1, -1, 32'h0};
      vt[11] = '{1'b0, 3'b010, 32'h400, 32'h0,    32'h0,         3'b001, 1, -1, 32'h0};
      vt[12] = '{1'b0, 3'b011, 32'h0,   32'h0,    32'h0,         3'b100, 1, -1, 32'h0};
      vt[13] = '{1'b0, 3'b010, 32'h3FC, 32'h0,    32'h1234_5678, 3'b000, 2, -1, 32'h0};
      vt[14] = '{1'b1, 3'b010, 32'h3FC, 32'hDEAD_BEEF, 32'h0,    3'b000, 2, 255, 32'hDEAD_BEEF};
      vt[15] = '{1'b1, 3'b100, 32'h0,   32'h77,   32'h0,         3'b100, 1, -1, 32'h0};

      for (int i = 0; i < 16; i++) begin
         model(vt[i].wr, vt[i].f3, vt[i].a, vt[i].sd, d_ld, d_ex, d_lat);
         exec_check($sformatf("vec%0d", i), vt[i].wr, vt[i].f3, vt[i].a, vt[i].sd,
                    vt[i].ld, vt[i].exc, vt[i].lat);
         if (vt[i].widx >= 0) check($sformatf("vec%0d mem", i), dmem[vt[i].widx], vt[i].wval);
      end

      // Reset during RMW_RD of an SB: the write must be dropped.
      @(negedge i_clk);
      for (int w = 0; w < 10 && !bus.req_rdy; w++) @(negedge i_clk);
      drive_req(1'b1, 3'b000, 32'h41, 32'h5A);
      bus.req_vld = 1'b1;
      @(posedge i_clk);
      #1 bus.req_vld = 1'b0;
      i_rst = 1'b1;
      @(negedge i_clk);
      check("mid-reset mem_rw", {30'h0, bus.mem_read, bus.mem_write}, 32'd0);
      check("mid-reset req_rdy", 32'(bus.req_rdy), 32'd0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check("after-reset req_rdy", 32'(bus.req_rdy), 32'd1);
      check("after-reset resp/exc", {28'h0, bus.resp_vld, bus.exc_illegal, bus.exc_misaligned, bus.exc_access}, 32'd0);
      check("after-reset load_dat", bus.load_dat, 32'h0);
      check("after-reset mem_rw", {30'h0, bus.mem_read, bus.mem_write}, 32'd0);
      check("after-reset mem_addr", bus.mem_addr, 32'h0);
      check("after-reset mem_wr_dat", bus.mem_wr_dat, 32'h0);
      check("after-reset mem_funct3", 32'(bus.mem_funct3), 32'd2);
      check("dropped store word", dmem[16], ref_word(16));

      // Back-to-back with valid held high: accepts only in IDLE, in-order responses.
      bb[0] = '{1'b0, 3'b010, 32'h80, 32'h0};
      bb[1] = '{1'b1, 3'b010, 32'h84, 32'hCAFE_F00D};
      bb[2] = '{1'b0, 3'b000, 32'h87, 32'h0};
      bb[3] = '{1'b0, 3'b101, 32'h86, 32'h0};
      for (int i = 0; i < 4; i++) model(bb[i].wr, bb[i].f3, bb[i].a, bb[i].sd, bb_ld[i], d_ex, d_lat);
      begin
         int idx, nresp;
         int acc_cyc [4];
         bit acc;
         idx = 0;
         nresp = 0;
         drive_req(bb[0].wr, bb[0].f3, bb[0].a, bb[0].sd);
         bus.req_vld = 1'b1;
         for (int c = 0; c < 40 && (idx < 4 || nresp < 4); c++) begin
            if (bus.resp_vld) begin
               if (nresp < 4) check($sformatf("b2b resp%0d", nresp), bus.load_dat, bb_ld[nresp]);
               nresp++;
            end
            acc = bus.req_vld && bus.req_rdy;
            @(posedge i_clk);
            #1;
            if (acc) begin
               acc_cyc[idx] = c;
               idx++;
               if (idx < 4) drive_req(bb[idx].wr, bb[idx].f3, bb[idx].a, bb[idx].sd);
               else bus.req_vld = 1'b0;
            end
            @(negedge i_clk);
         end
         bus.req_vld = 1'b0;
         check("b2b accepts", idx, 4);
         check("b2b responses", nresp, 4);
         if (idx == 4) begin
            for (int i = 1; i < 4; i++)
               check($sformatf("b2b spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
         end
      end

      for (int it = 0; it < 150; it++) begin
         bit        wr;
         bit [2:0]  f3;
         bit [31:0] a, sd, e_ld;
         bit [2:0]  e_ex;
         int        e_lat;
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 8) f3 = wr ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
         else f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(1024, 1100));
         else a = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
         sd = $urandom;
         model(wr, f3, a, sd, e_ld, e_ex, e_lat);
         exec_check($sformatf("rnd%0d", it), wr, f3, a, sd, e_ld, e_ex, e_lat);
         if (a < 32'd1024) check($sformatf("rnd%0d mem", it), dmem[a[9:2]], ref_word(int'(a[9:2])));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
